axis_frame_source: RTL and testbench
====================================

Name: axis_frame_source

Overview:
AXI-Stream frame transmitter that drives the slave side of the team's frame FIFO and downstream stream blocks. On a start pulse it emits a programmable number of frames. Each frame has a programmable length, an inter-frame gap and a selectable data pattern, and m_tlast is asserted on the final beat of each frame. It is the stimulus/traffic source for the stream datapath, and it obeys full AXIS backpressure.

Parameters:
DW, 16, stream data width; must be ≥16.
LW, 12, frame-length counter width; max frame = 2**(LW-1) = DD.
DD, 2048, maximum frame length in beats.
GW, 8, inter-frame gap counter width.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; latches config, begins transmission (ignored while busy)
stop  in  1  pulse; finish current frame (through tlast), then return to IDLE
mode  in  2  pattern: 0 = beat index, 1 = LFSR16, 2 = {frame_cnt[7:0], beat[7:0]}, 3 = constant 16'hA5A5
frame_len  in  LW+1  beats per frame; 0 or >DD treated as DD
gap_len  in  GW  idle cycles between frames
num_frames  in  16  frames to send; 0 = continuous until stop
m_tdata  out  DW  stream data (16-bit pattern zero-extended)
m_tvalid  out  1  stream valid
m_tlast  out  1  last beat of frame
m_tready  in  1  downstream ready
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse when transmission completes
frame_cnt  out  16  frames completed since last start (wraps at 2**16)

Behaviour:
- Reset is synchronous and active-high: rst = 1 on a clk edge clears all state. After that edge: m_tvalid = 0, m_tlast = 0, m_tdata = 0, busy = 0, done = 0, frame_cnt = 0, state = IDLE, LFSR = 16'hACE1.
- Reset mid-frame aborts immediately. No m_tlast is emitted.
- All outputs are registered. There is no combinational path from m_tready to any output.
- Beat transfer occurs on any cycle with m_tvalid && m_tready.
- Once m_tvalid is high, m_tdata, m_tlast and m_tvalid hold until the transfer occurs. A source never retracts valid.
- State IDLE:
  - start = 1 latches mode, frame_len, gap_len and num_frames into shadow registers, and clears frame_cnt, beat counter and LFSR (to seed 16'hACE1).
  - Next state SEND. busy = 1 and m_tvalid = 1 with beat 0 on the next cycle (latency 1).
- State SEND:
  - On each transfer, beat++ and the next pattern word is loaded.
  - m_tlast = 1 exactly when beat == len-1.
  - On the transfer of the tlast beat: frame_cnt++.
  - If (num_frames != 0 && frame_cnt+1 == num_frames) or a stop is pending, go to IDLE. m_tvalid = 0, busy = 0 and done = 1 on the next cycle.
  - Otherwise, if gap_len == 0, the next frame's beat 0 is presented the next cycle (m_tvalid stays high).
  - Otherwise go to GAP with m_tvalid = 0.
- State GAP:
  - m_tvalid is held low for exactly gap_len cycles.
  - Then beat 0 of the next frame is presented; the state returns to SEND.
- stop:
  - A stop pulse in SEND or GAP sets stop_pending.
  - In GAP, it ends immediately: IDLE plus done next cycle, with no further frame started.
  - A stop pulse in IDLE is ignored.
  - A simultaneous start and stop in IDLE lets start win; the stop is ignored.
- Patterns:
  - Beat index is zero-extended; it is 16-bit, so indices wrap only when DD > 65536.
  - LFSR is Fibonacci, taps x^16 + x^14 + x^13 + x^11 + 1. It advances once per transfer and continues across frames.
  - Mode 2 uses the current frame_cnt and beat truncated to 8 bits each.
- Config inputs are sampled only at start. Changes while busy have no effect.

Decomposition:
- Package axis_src_pkg holds:
  - typedef enum for mode (PAT_INDEX, PAT_LFSR, PAT_FRAME, PAT_CONST);
  - typedef enum for state (IDLE, SEND, GAP);
  - localparams LFSR_SEED = 16'hACE1, LFSR_TAPS = 16'hB400, CONST_WORD = 16'hA5A5.
- Sub-module axis_pattern_gen: given mode, beat, frame_cnt and an advance strobe, it produces the next 16-bit word and holds the LFSR state.
- The top level holds the FSM, counters and the output register.

Test Plan:
1. mode=0, frame_len=4, num_frames=1, gap=0, m_tready=1 → tdata 0,1,2,3 on consecutive cycles. tlast on data 3. done pulses the cycle after, busy drops, frame_cnt = 1.
2. Same as scenario 1 with m_tready pattern 1,0,0,1,0,1,1 → each word is held stable while ready is low. Exactly 4 transfers, in order 0..3, with tlast only on 3.
3. mode=0, frame_len=3, gap_len=3, num_frames=2, ready=1 → 3 beats, exactly 3 cycles with tvalid = 0, 3 beats, done. frame_cnt = 2.
4. frame_len=0, mode=1 → 2048 beats, with tlast only on beat 2047. The first three words match the LFSR from seed 16'hACE1 (the bench reference model computes them).
5. num_frames=0, frame_len=5, stop pulsed at beat 2 of frame 3 → frame 3 completes through tlast and no frame 4 starts. done pulses; frame_cnt = 3.
6. rst asserted mid-frame at beat 100 → the next cycle has m_tvalid = 0, m_tlast = 0, busy = 0 and frame_cnt = 0. A following start yields beat 0 with data 0.

Source files
------------

// File: rtl/axis_src_pkg.sv
// rtl/axis_src_pkg.sv - shared types and constants for the AXIS frame source
package axis_src_pkg;

    typedef enum logic [1:0] {
        PAT_INDEX = 2'd0,
        PAT_LFSR  = 2'd1,
        PAT_FRAME = 2'd2,
        PAT_CONST = 2'd3
    } pat_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] CONST_WORD = 16'hA5A5;

    // Fibonacci step: parity of the tapped bits shifts in at the bottom
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_frame_source_if.sv
// rtl/axis_frame_source_if.sv - AXI-Stream beat interface of the frame source
interface axis_frame_source_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - next data word for the frame source, owns the LFSR
module axis_pattern_gen
    import axis_src_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pat_mode_t   mode,
    input  logic [15:0] beat,
    input  logic [7:0]  frame_lo,
    input  logic        seed_load,
    input  logic        advance,
    output logic [15:0] word
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Word reflects the post-update LFSR so the loaded beat matches the step just taken
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
        case (mode)
            PAT_INDEX: word = beat;
            PAT_LFSR:  word = lfsr_d;
            PAT_FRAME: word = {frame_lo, beat[7:0]};
            PAT_CONST: word = CONST_WORD;
            default:   word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/axis_frame_source.sv
// rtl/axis_frame_source.sv - programmable AXIS frame transmitter with gaps and backpressure
module axis_frame_source
    import axis_src_pkg::*;
#(
    parameter int DW = 16,
    parameter int LW = 12,
    parameter int DD = 2048,
    parameter int GW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [LW:0]         frame_len,
    input  logic [GW-1:0]       gap_len,
    input  logic [15:0]         num_frames,
    axis_frame_source_if.master m,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_cnt
);

    localparam logic [LW:0]   DD_L    = (LW+1)'(DD);
    localparam logic [LW:0]   ONE_L   = 1;
    localparam logic [GW-1:0] GAP_ONE = 1;

    state_t        state_q, state_d;
    pat_mode_t     mode_q, mode_d;
    logic [LW:0]   len_q, len_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   nf_q, nf_d;
    logic [LW:0]   beat_q, beat_d;
    logic [15:0]   fc_q, fc_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          stop_pend_q, stop_pend_d;
    logic [15:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [LW:0]   len_in;
    logic [LW:0]   beat_inc;
    logic [15:0]   fc_inc;
    logic          xfer;
    pat_mode_t     pg_mode;
    logic [15:0]   pg_beat;
    logic [15:0]   pg_frame;
    logic          pg_seed;
    logic          pg_adv;
    logic [15:0]   pg_word;

    axis_pattern_gen u_pat (
        .clk       (clk),
        .rst       (rst),
        .mode      (pg_mode),
        .beat      (pg_beat),
        .frame_lo  (pg_frame[7:0]),
        .seed_load (pg_seed),
        .advance   (pg_adv),
        .word      (pg_word)
    );

    assign len_in   = (frame_len == '0 || frame_len > DD_L) ? DD_L : frame_len;
    assign beat_inc = beat_q + ONE_L;
    assign fc_inc   = fc_q + 16'd1;
    assign xfer     = tvalid_q && m.tready;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        gap_d       = gap_q;
        nf_d        = nf_q;
        beat_d      = beat_q;
        fc_d        = fc_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pg_mode     = mode_q;
        pg_beat     = 16'(beat_q);
        pg_frame    = fc_q;
        pg_seed     = 1'b0;
        pg_adv      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = pat_mode_t'(mode);
                    len_d       = len_in;
                    gap_d       = gap_len;
                    nf_d        = num_frames;
                    fc_d        = '0;
                    beat_d      = '0;
                    stop_pend_d = 1'b0;
                    pg_mode     = pat_mode_t'(mode);
                    pg_beat     = '0;
                    pg_frame    = '0;
                    pg_seed     = 1'b1;
                    tdata_d     = pg_word;
                    tvalid_d    = 1'b1;
                    tlast_d     = (len_in == ONE_L);
                    busy_d      = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (xfer) begin
                    pg_adv = 1'b1;
                    if (tlast_q) begin
                        fc_d = fc_inc;
                        // A stop arriving on the last beat itself still ends the run here
                        if ((nf_q != '0 && fc_inc == nf_q) || stop_pend_q || stop) begin
                            state_d     = IDLE;
                            tvalid_d    = 1'b0;
                            tlast_d     = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else if (gap_q == '0) begin
                            beat_d   = '0;
                            pg_beat  = '0;
                            pg_frame = fc_inc;
                            tdata_d  = pg_word;
                            tlast_d  = (len_q == ONE_L);
                        end else begin
                            state_d   = GAP;
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_d  = beat_inc;
                        pg_beat = 16'(beat_inc);
                        tdata_d = pg_word;
                        tlast_d = (beat_inc == len_q - ONE_L);
                    end
                end
            end
            GAP: begin
                if (stop || stop_pend_q) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q <= GAP_ONE) begin
                    state_d  = SEND;
                    beat_d   = '0;
                    pg_beat  = '0;
                    tdata_d  = pg_word;
                    tvalid_d = 1'b1;
                    tlast_d  = (len_q == ONE_L);
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= PAT_INDEX;
            len_q       <= '0;
            gap_q       <= '0;
            nf_q        <= '0;
            beat_q      <= '0;
            fc_q        <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            nf_q        <= nf_d;
            beat_q      <= beat_d;
            fc_q        <= fc_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m.tdata   = DW'(tdata_q);
    assign m.tvalid  = tvalid_q;
    assign m.tlast   = tlast_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// tb/tb_axis_frame_source.sv - self-checking bench for axis_frame_source
module tb_axis_frame_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [12:0] frame_len;
    logic [7:0]  gap_len;
    logic [15:0] num_frames;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    axis_frame_source_if #(.DW(16)) s_if ();

    axis_frame_source #(.DW(16), .LW(12), .DD(2048), .GW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .frame_len  (frame_len),
        .gap_len    (gap_len),
        .num_frames (num_frames),
        .m          (s_if),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    md;
        int    len;
        int    gap;
        int    nf;
        int    rdy;        // 0 always ready, 1 fixed 1,0,0,1,0,1,1 pattern, 2 random
        int    stop_beat;  // global beat index at which stop pulses, -1 none
        int    sws;        // stop together with start
        int    exp_beats;
        int    exp_frames;
    } vec_t;

    vec_t tbl[11];

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_data[$];
    logic        exp_last[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // Reference: every beat the source should emit, built frame by frame
    task automatic build_model(input int md, input int len, input int nf, input int stop_beat,
                               output int frames);
        int          l;
        logic [15:0] lf;
        logic [15:0] f16;
        logic [15:0] b16;
        l = (len == 0 || len > 2048) ? 2048 : len;
        if (stop_beat >= 0) begin
            frames = stop_beat / l + 1;
            if (nf != 0 && nf < frames) frames = nf;
        end else begin
            frames = nf;
        end
        exp_data.delete();
        exp_last.delete();
        lf = 16'hACE1;
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < l; b++) begin
                f16 = 16'(f);
                b16 = 16'(b);
                case (md)
                    0:       exp_data.push_back(b16);
                    1:       exp_data.push_back(lf);
                    2:       exp_data.push_back({f16[7:0], b16[7:0]});
                    default: exp_data.push_back(16'hA5A5);
                endcase
                exp_last.push_back(b == l - 1);
                lf = lfsr_next(lf);
            end
        end
    endtask

    task automatic run(input vec_t v);
        int          frames;
        int          xfers;
        int          idle;
        bit          held;
        bit          finished;
        bit          stop_sent;
        bit          r;
        logic [15:0] hd;
        logic        hl;
        logic [6:0]  rp;
        rp = 7'b1101001;
        build_model(v.md, v.len, v.nf, v.stop_beat, frames);
        mode       = 2'(v.md);
        frame_len  = 13'(v.len);
        gap_len    = 8'(v.gap);
        num_frames = 16'(v.nf);
        start      = 1'b1;
        stop       = v.sws[0];
        s_if.tready = 1'b0;
        @(posedge clk); #1;
        chk({v.name, "_start_busy"}, busy, 1);
        chk({v.name, "_start_valid"}, s_if.tvalid, 1);
        xfers = 0; idle = 0; held = 0; finished = 0; stop_sent = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            start = 1'b0;
            stop  = 1'b0;
            if (done) begin
                finished = 1;
                break;
            end
            if (held) begin
                chk({v.name, "_hold_valid"}, s_if.tvalid, 1);
                chk({v.name, "_hold_data"}, s_if.tdata, hd);
                chk({v.name, "_hold_last"}, s_if.tlast, hl);
            end
            r = (v.rdy == 0) ? 1'b1 : (v.rdy == 1) ? rp[cyc % 7] : 1'($urandom_range(0, 1));
            s_if.tready = r;
            if (!stop_sent && v.stop_beat >= 0 && xfers == v.stop_beat && s_if.tvalid) begin
                stop = 1'b1;
                stop_sent = 1;
            end
            if (busy && $urandom_range(0, 9) == 0) start = 1'b1;
            mode       = 2'($urandom);
            frame_len  = 13'($urandom);
            gap_len    = 8'($urandom);
            num_frames = 16'($urandom);
            if (busy && !s_if.tvalid) idle++;
            if (s_if.tvalid && r) begin
                if (exp_data.size() == 0) begin
                    fail_now({v.name, "_extra_beat"}, xfers + 1, xfers);
                end else begin
                    chk({v.name, "_data"}, s_if.tdata, exp_data.pop_front());
                    chk({v.name, "_last"}, s_if.tlast, exp_last.pop_front());
                end
                xfers++;
                held = 0;
            end else if (s_if.tvalid) begin
                held = 1;
                hd = s_if.tdata;
                hl = s_if.tlast;
            end else begin
                held = 0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        s_if.tready = 1'b0;
        if (!finished) fail_now({v.name, "_timeout"}, 0, 1);
        chk({v.name, "_done_busy"}, busy, 0);
        chk({v.name, "_done_valid"}, s_if.tvalid, 0);
        chk({v.name, "_frame_cnt"}, frame_cnt, 16'(frames));
        chk({v.name, "_missing_beats"}, exp_data.size(), 0);
        chk({v.name, "_gap_cycles"}, idle, v.gap * (frames - 1));
        if (v.exp_beats >= 0) chk({v.name, "_beats"}, xfers, v.exp_beats);
        if (v.exp_frames >= 0) chk({v.name, "_frames"}, frame_cnt, v.exp_frames);
        @(posedge clk); #1;
        chk({v.name, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int   n;
        vec_t rv;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; frame_len = '0;
        gap_len = '0; num_frames = '0; s_if.tready = 1'b0;

        tbl[0]  = '{"t1_basic",    0, 4,    0, 1, 0, -1, 0, 4,    1};
        tbl[1]  = '{"t2_backpr",   0, 4,    0, 1, 1, -1, 0, 4,    1};
        tbl[2]  = '{"t3_gap",      0, 3,    3, 2, 0, -1, 0, 6,    2};
        tbl[3]  = '{"t4_lfsr_max", 1, 0,    0, 1, 0, -1, 0, 2048, 1};
        tbl[4]  = '{"t5_stop",     0, 5,    0, 0, 0, 12, 0, 15,   3};
        tbl[5]  = '{"frame_pat",   2, 7,    2, 3, 2, -1, 0, 21,   3};
        tbl[6]  = '{"const_len1",  3, 1,    0, 4, 2, -1, 0, 4,    4};
        tbl[7]  = '{"len_over",    1, 3000, 0, 1, 2, -1, 0, 2048, 1};
        tbl[8]  = '{"start_stop",  0, 3,    1, 2, 0, -1, 1, 6,    2};
        tbl[9]  = '{"stop_rand",   2, 4,    0, 0, 2, 9,  0, 12,   3};
        tbl[10] = '{"len1_gap",    1, 1,    5, 3, 2, -1, 0, 3,    3};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", s_if.tvalid, 0);
        chk("rst_last", s_if.tlast, 0);
        chk("rst_data", s_if.tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        for (int i = 0; i < 11; i++) run(tbl[i]);

        // Reset in the middle of a long frame
        mode = 2'd0; frame_len = 13'd200; gap_len = 8'd0; num_frames = 16'd1;
        start = 1'b1; s_if.tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 400 && n < 100; c++) begin
            if (s_if.tvalid) n++;
            @(posedge clk); #1;
        end
        chk("midrst_reached", n, 100);
        chk("midrst_beat100", s_if.tdata, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", s_if.tvalid, 0);
        chk("midrst_last", s_if.tlast, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        rv = '{"after_rst", 0, 4, 0, 1, 0, -1, 0, 4, 1};
        run(rv);

        // Stop while the gap is running: ends at once, no further frame
        mode = 2'd0; frame_len = 13'd2; gap_len = 8'd10; num_frames = 16'd0;
        start = 1'b1; s_if.tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && frame_cnt != 16'd1; c++) begin
            @(posedge clk); #1;
        end
        chk("gapstop_first_frame", frame_cnt, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("gapstop_in_gap", s_if.tvalid, 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("gapstop_done", done, 1);
        chk("gapstop_busy", busy, 0);
        chk("gapstop_valid", s_if.tvalid, 0);
        chk("gapstop_frame_cnt", frame_cnt, 1);
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("gapstop_no_restart", s_if.tvalid, 0);
        s_if.tready = 1'b0;

        for (int k = 0; k < 8; k++) begin
            rv.name = $sformatf("rand%0d", k);
            rv.md   = $urandom_range(0, 3);
            rv.len  = $urandom_range(1, 40);
            rv.gap  = $urandom_range(0, 4);
            rv.rdy  = 2;
            rv.sws  = 0;
            rv.exp_beats  = -1;
            rv.exp_frames = -1;
            if ($urandom_range(0, 2) == 0) begin
                rv.nf = 0;
                rv.stop_beat = $urandom_range(0, rv.len * 3);
            end else begin
                rv.nf = $urandom_range(1, 4);
                rv.stop_beat = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, rv.len * 4);
            end
            run(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
